tinker_decode_issue: RTL
========================

Name: tinker_decode_issue

Overview:
- Decode/issue stage directly upstream of the Tinker register file.
- Accepts fetched 32-bit instructions and drives the register-file read addresses. Captures the operands into one output pipeline register for the execute stage.
- A 32-entry busy scoreboard stalls RAW and WAW hazards until writeback clears the destination.

Parameters:
- XLEN, 64, datapath/register width
- NUM_REGS, 32, architectural registers (5-bit address)
- ILEN, 32, instruction width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  fetch has instruction
- in_ready  output  1  stage accepts this cycle
- in_instr  input  32  opcode[31:27] rd[26:22] rs[21:17] rt[16:12] L[11:0]
- in_pc  input  64  instruction address
- rf_rs_addr  output  5  register-file read port A address
- rf_rt_addr  output  5  register-file read port B address
- rf_rs_data  input  64  port A data (combinational read)
- rf_rt_data  input  64  port B data
- wb_valid  input  1  writeback retiring a register write
- wb_rd  input  5  register being written back
- flush  input  1  kill held instruction
- out_valid  output  1  output register holds instruction
- out_ready  input  1  execute consumes
- out_opcode  output  5  decoded opcode
- out_rd  output  5  destination
- out_a  output  64  operand A
- out_b  output  64  operand B
- out_pc  output  64  captured PC
- out_writes_rd  output  1  instruction writes rd
- out_illegal  output  1  opcode > 0x1D
- sb_busy  output  32  scoreboard bitmap

Behaviour:
- Reset (sync, high): out_valid=0, all out_* data=0, sb_busy=0. Reset has priority over every other input, including mid-stall and mid-flush.
- Read-address mapping, combinational from in_instr:
  - IMM ops {0x05 shftri, 0x07 shftli, 0x12 mov rd,L, 0x19 addi, 0x1B subi}: rf_rs_addr=rd.
  - All other ops: rf_rs_addr=rs.
  - rf_rt_addr=rt always.
- Sources:
  - reads_a=1 always.
  - reads_b = !IMM.
- writes_rd = 0 for opcodes 0x08-0x0F (branch/priv) and 0x13 (store) and illegal opcodes; 1 otherwise.
- hazard = (busy[rf_rs_addr]) | (reads_b & busy[rt]) | (writes_rd & busy[rd]). Use the registered sb_busy only; there is no writeback bypass.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready. Next edge, the output register loads:
  - out_a = rf_rs_data
  - out_b = IMM ? zero-extend(L) : rf_rt_data
  - opcode, rd, pc, writes_rd, illegal
  - out_valid=1
  - Latency in->out: 1 cycle.
- Output handshake:
  - Fire = out_valid & out_ready.
  - Fire without a new accept: out_valid->0.
  - Fire with a new accept in the same cycle: the register reloads with no bubble.
  - While out_valid & !out_ready, all out_* are held stable.
- Scoreboard:
  - Set busy[rd] on accept when writes_rd=1.
  - Clear busy[wb_rd] on wb_valid.
  - Same register set and cleared in one cycle: set wins.
  - wb to a non-busy register: no effect, no error.
- Flush (no reset):
  - Next cycle out_valid=0.
  - If the held instruction had writes_rd, clear busy[out_rd] unless it is re-set the same cycle.
  - No accept occurs that cycle.
  - Other busy bits are unaffected.
- Illegal opcode: accepted normally, out_illegal=1, writes_rd=0, no scoreboard set.

Decomposition:
- Package tinker_pkg holds:
  - opcode localparams (0x00-0x1D)
  - field-position constants
  - the is_imm_rdsrc() and writes_rd() decode functions
  - instr_fields_t struct
- Sub-module tinker_scoreboard: busy bitmap with set/clear/flush-clear ports and the hazard query.

Test Plan:
- Reset asserted 2 cycles, then released -> out_valid=0, sb_busy=0, in_ready=1 with in_valid=0.
- add r3,r1,r2 (opcode 0x18), rf r1=5, r2=7 -> rf_rs_addr=1, rf_rt_addr=2. Next cycle: out_valid=1, out_a=5, out_b=7, out_rd=3, sb_busy[3]=1.
- sub r4,r3,r1 while busy[3] -> in_ready=0 held. wb_valid, wb_rd=3 in cycle N -> accepted in cycle N+1, out_valid in N+2.
- addi r5,0xFFF with r5=0x10 -> rf_rs_addr=5, out_a=0x10, out_b=0x0000000000000FFF, busy[5]=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged, in_ready=0. Then out_ready=1 -> back-to-back reload, no bubble.
- Flush with held add r3 (busy[3]=1) -> next cycle out_valid=0, busy[3]=0. Reset asserted during a RAW stall -> sb_busy=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/tinker_pkg.sv
// Shared decode definitions for the Tinker decode/issue stage.
// Holds the opcode map, instruction field positions, the unpacked field
// struct and the small decode functions used by the issue logic and the
// scoreboard hookup.
package tinker_pkg;

  localparam int ILEN_C   = 32;
  localparam int REG_AW   = 5;
  localparam int IMM_W    = 12;

  // Field positions within the 32-bit instruction word.
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 22;
  localparam int RS_MSB   = 21;
  localparam int RS_LSB   = 17;
  localparam int RT_MSB   = 16;
  localparam int RT_LSB   = 12;
  localparam int IMM_MSB  = 11;
  localparam int IMM_LSB  = 0;

  localparam logic [4:0] OP_AND     = 5'h00;
  localparam logic [4:0] OP_OR      = 5'h01;
  localparam logic [4:0] OP_XOR     = 5'h02;
  localparam logic [4:0] OP_NOT     = 5'h03;
  localparam logic [4:0] OP_SHFTR   = 5'h04;
  localparam logic [4:0] OP_SHFTRI  = 5'h05;
  localparam logic [4:0] OP_SHFTL   = 5'h06;
  localparam logic [4:0] OP_SHFTLI  = 5'h07;
  localparam logic [4:0] OP_BR      = 5'h08;
  localparam logic [4:0] OP_BRR     = 5'h09;
  localparam logic [4:0] OP_BRRL    = 5'h0A;
  localparam logic [4:0] OP_BRNZ    = 5'h0B;
  localparam logic [4:0] OP_CALL    = 5'h0C;
  localparam logic [4:0] OP_RETURN  = 5'h0D;
  localparam logic [4:0] OP_BRGT    = 5'h0E;
  localparam logic [4:0] OP_PRIV    = 5'h0F;
  localparam logic [4:0] OP_MOV_LD  = 5'h10;
  localparam logic [4:0] OP_MOV_RR  = 5'h11;
  localparam logic [4:0] OP_MOV_RL  = 5'h12;
  localparam logic [4:0] OP_MOV_ST  = 5'h13;
  localparam logic [4:0] OP_ADDF    = 5'h14;
  localparam logic [4:0] OP_SUBF    = 5'h15;
  localparam logic [4:0] OP_MULF    = 5'h16;
  localparam logic [4:0] OP_DIVF    = 5'h17;
  localparam logic [4:0] OP_ADD     = 5'h18;
  localparam logic [4:0] OP_ADDI    = 5'h19;
  localparam logic [4:0] OP_SUB     = 5'h1A;
  localparam logic [4:0] OP_SUBI    = 5'h1B;
  localparam logic [4:0] OP_MUL     = 5'h1C;
  localparam logic [4:0] OP_DIV     = 5'h1D;
  localparam logic [4:0] OP_MAX     = OP_DIV;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [IMM_W-1:0]  imm;
  } instr_fields_t;

  function automatic instr_fields_t unpack_instr(input logic [ILEN_C-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPC_MSB:OPC_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.imm    = instr[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  function automatic logic is_illegal(input logic [4:0] opc);
    return opc > OP_MAX;
  endfunction

  // Immediate forms read rd as their first source and take L as operand B.
  function automatic logic is_imm_rdsrc(input logic [4:0] opc);
    logic r;
    case (opc)
      OP_SHFTRI, OP_SHFTLI, OP_MOV_RL, OP_ADDI, OP_SUBI: r = 1'b1;
      default:                                           r = 1'b0;
    endcase
    return r;
  endfunction

  // Branch/priv, store and illegal opcodes never retire a register write.
  function automatic logic writes_rd(input logic [4:0] opc);
    logic r;
    r = 1'b1;
    if (opc >= OP_BR && opc <= OP_PRIV) r = 1'b0;
    if (opc == OP_MOV_ST)               r = 1'b0;
    if (is_illegal(opc))                r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/tinker_scoreboard.sv
// Busy bitmap for the architectural registers.
// Ports: set (issue of a writing instruction), clr (writeback retire),
// flush_clr (killed held instruction), three hazard query indices with
// enables for the B-source and destination, hazard_o and the bitmap busy_o.
module tinker_scoreboard
  import tinker_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en_i,
  input  logic [REG_AW-1:0]   set_idx_i,
  input  logic                clr_en_i,
  input  logic [REG_AW-1:0]   clr_idx_i,
  input  logic                flush_clr_en_i,
  input  logic [REG_AW-1:0]   flush_clr_idx_i,
  input  logic [REG_AW-1:0]   q_a_idx_i,
  input  logic                q_b_en_i,
  input  logic [REG_AW-1:0]   q_b_idx_i,
  input  logic                q_d_en_i,
  input  logic [REG_AW-1:0]   q_d_idx_i,
  output logic                hazard_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clears first, set last so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i)       busy_d[clr_idx_i]       = 1'b0;
    if (flush_clr_en_i) busy_d[flush_clr_idx_i] = 1'b0;
    if (set_en_i)       busy_d[set_idx_i]       = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Registered state only: a writeback this cycle does not release a stall
  // until the next cycle.
  assign hazard_o = busy_q[q_a_idx_i]
                  | (q_b_en_i & busy_q[q_b_idx_i])
                  | (q_d_en_i & busy_q[q_d_idx_i]);

  assign busy_o = busy_q;

endmodule

// File: rtl/tinker_decode_issue.sv
// Tinker decode/issue stage.
// Decodes a fetched instruction, drives the register-file read addresses,
// stalls on RAW/WAW hazards against the busy scoreboard and captures the
// operands into a single output register with a valid/ready handshake.
// Ports: fetch side (in_valid/in_ready/in_instr/in_pc), register-file read
// ports (rf_*), writeback (wb_valid/wb_rd), flush, execute side (out_*),
// and the scoreboard bitmap sb_busy.
module tinker_decode_issue
  import tinker_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int ILEN     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ILEN-1:0]     in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic [REG_AW-1:0]   rf_rs_addr,
  output logic [REG_AW-1:0]   rf_rt_addr,
  input  logic [XLEN-1:0]     rf_rs_data,
  input  logic [XLEN-1:0]     rf_rt_data,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_opcode,
  output logic [REG_AW-1:0]   out_rd,
  output logic [XLEN-1:0]     out_a,
  output logic [XLEN-1:0]     out_b,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_writes_rd,
  output logic                out_illegal,
  output logic [NUM_REGS-1:0] sb_busy
);

  instr_fields_t f;
  logic dec_imm, dec_illegal, dec_writes_rd;
  logic hazard, accept, fire;

  assign f             = unpack_instr(in_instr);
  assign dec_imm       = is_imm_rdsrc(f.opcode);
  assign dec_illegal   = is_illegal(f.opcode);
  assign dec_writes_rd = writes_rd(f.opcode);

  assign rf_rs_addr = dec_imm ? f.rd : f.rs;
  assign rf_rt_addr = f.rt;

  logic                valid_q, valid_d;
  logic [4:0]          opcode_q, opcode_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic                wr_q, wr_d, ill_q, ill_d;

  tinker_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk             (clk),
    .reset           (reset),
    .set_en_i        (accept & dec_writes_rd),
    .set_idx_i       (f.rd),
    .clr_en_i        (wb_valid),
    .clr_idx_i       (wb_rd),
    .flush_clr_en_i  (flush & valid_q & wr_q),
    .flush_clr_idx_i (rd_q),
    .q_a_idx_i       (rf_rs_addr),
    .q_b_en_i        (~dec_imm),
    .q_b_idx_i       (f.rt),
    .q_d_en_i        (dec_writes_rd),
    .q_d_idx_i       (f.rd),
    .hazard_o        (hazard),
    .busy_o          (sb_busy)
  );

  // Flush blocks acceptance outright, so a flush never coincides with a set.
  assign in_ready = ~flush & ~hazard & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign fire     = valid_q & out_ready;

  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    pc_d     = pc_q;
    wr_d     = wr_q;
    ill_d    = ill_q;
    if (accept) begin
      valid_d  = 1'b1;
      opcode_d = f.opcode;
      rd_d     = f.rd;
      a_d      = rf_rs_data;
      b_d      = dec_imm ? {{(XLEN-IMM_W){1'b0}}, f.imm} : rf_rt_data;
      pc_d     = in_pc;
      wr_d     = dec_writes_rd;
      ill_d    = dec_illegal;
    end else if (flush || fire) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pc_q     <= '0;
      wr_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pc_q     <= pc_d;
      wr_q     <= wr_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_opcode    = opcode_q;
  assign out_rd        = rd_q;
  assign out_a         = a_q;
  assign out_b         = b_q;
  assign out_pc        = pc_q;
  assign out_writes_rd = wr_q;
  assign out_illegal   = ill_q;

endmodule
